// File: rtl/mem_arbiter.sv
// Shares one word-wide memory port between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.

module mem_arbiter_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0]  size,
    input  logic [1:0]  woff,
    input  logic [31:0] store,
    input  logic [1:0]  loff,
    input  logic [31:0] rdata,
    output logic        strb,
    output logic [7:0]  wbyte,
    output logic [7:0]  lbyte
);
    localparam logic [1:0] L    = 2'(LANE);
    localparam int         HSEL = LANE % 2;

    logic [2:0] src;

    // Store data is replicated into every lane so only the strobe picks the target bytes.
    always_comb begin
        strb  = 1'b0;
        wbyte = 8'h00;
        case (size)
            2'b00: begin
                strb  = (woff == L);
                wbyte = store[7:0];
            end
            2'b01: begin
                strb  = (woff[1] == L[1]);
                wbyte = store[8*HSEL +: 8];
            end
            2'b10: begin
                strb  = 1'b1;
                wbyte = store[8*LANE +: 8];
            end
            default: ;
        endcase
    end

    assign src   = {1'b0, L} + {1'b0, loff};
    assign lbyte = src[2] ? 8'h00 : rdata[8*src[1:0] +: 8];
endmodule

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        imem_ren,
    input  logic [31:0] imem_addr,
    output logic        ihit,
    output logic [31:0] imem_load,
    input  logic        dmem_ren,
    input  logic        dmem_wen,
    input  logic [31:0] dmem_addr,
    input  logic [2:0]  dmem_width,
    input  logic [31:0] dmem_store,
    output logic        dhit,
    output logic [31:0] dmem_load,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    localparam int NUM_LANES = 4;
    localparam int CW        = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

    state_t  state, state_nxt;
    logic [CW-1:0] cnt;
    logic    abort;
    logic    lat_wr;
    logic [1:0] lat_off;
    logic    grant_i, grant_d;
    logic    d_req, d_legal, d_valid, d_write, force_i;

    logic [NUM_LANES-1:0]        lane_strb;
    logic [NUM_LANES-1:0][7:0]   lane_wbyte;
    logic [NUM_LANES-1:0][7:0]   lane_lbyte;

    logic unused_ok;
    assign unused_ok = ^{dmem_width[2], imem_addr[1:0]};

    assign d_req   = dmem_ren | dmem_wen;
    assign d_write = dmem_wen & ~dmem_ren;
    assign d_legal = (dmem_width[1:0] != 2'b11)
                   && !(dmem_width[1:0] == 2'b01 && dmem_addr[0])
                   && !(dmem_width[1:0] == 2'b10 && dmem_addr[1:0] != 2'b00);
    assign d_valid = d_req & d_legal;
    assign force_i = imem_ren && (cnt == CNT_MAX);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mem_arbiter_lane #(.LANE(i)) u_lane (
            .size  (dmem_width[1:0]),
            .woff  (dmem_addr[1:0]),
            .store (dmem_store),
            .loff  (lat_off),
            .rdata (mem_rdata),
            .strb  (lane_strb[i]),
            .wbyte (lane_wbyte[i]),
            .lbyte (lane_lbyte[i])
        );
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        ihit      = 1'b0;
        dhit      = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        imem_load = 32'h0;
        dmem_load = 32'h0;
        case (state)
            IDLE: begin
                if (d_valid && !force_i) begin
                    grant_d   = 1'b1;
                    state_nxt = DBUSY;
                end else if (imem_ren) begin
                    grant_i   = 1'b1;
                    state_nxt = IBUSY;
                end
            end
            IBUSY: begin
                mem_ren = 1'b1;
                if (mem_ready) begin
                    ihit      = imem_ren && !abort;
                    state_nxt = IDLE;
                end
            end
            DBUSY: begin
                mem_ren = ~lat_wr;
                mem_wen = lat_wr;
                if (mem_ready) begin
                    dhit      = d_req && !abort;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (ihit) imem_load = mem_rdata;
        if (dhit) dmem_load = lane_lbyte;
    end

    // Bus-side values are captured at grant so requester changes never disturb a live access.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt       <= '0;
            abort     <= 1'b0;
            lat_wr    <= 1'b0;
            lat_off   <= 2'b00;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
        end else if (grant_i) begin
            cnt       <= '0;
            abort     <= 1'b0;
            lat_wr    <= 1'b0;
            lat_off   <= 2'b00;
            mem_addr  <= {imem_addr[31:2], 2'b00};
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
        end else if (grant_d) begin
            if (imem_ren && cnt != CNT_MAX) cnt <= cnt + 1'b1;
            abort     <= 1'b0;
            lat_wr    <= d_write;
            lat_off   <= dmem_addr[1:0];
            mem_addr  <= {dmem_addr[31:2], 2'b00};
            mem_wdata <= d_write ? lane_wbyte : 32'h0;
            mem_wstrb <= d_write ? lane_strb : 4'h0;
        end else if ((state == IBUSY && !imem_ren) || (state == DBUSY && !d_req)) begin
            abort <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a byte-range reference model.

module tb_mem_arbiter;
    localparam int SL = 2;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        imem_ren = 1'b0;
    logic [31:0] imem_addr = '0;
    logic        ihit;
    logic [31:0] imem_load;
    logic        dmem_ren = 1'b0, dmem_wen = 1'b0;
    logic [31:0] dmem_addr = '0;
    logic [2:0]  dmem_width = '0;
    logic [31:0] dmem_store = '0;
    logic        dhit;
    logic [31:0] dmem_load;
    logic        mem_ren, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(SL)) dut (
        .clk(clk), .nrst(nrst),
        .imem_ren(imem_ren), .imem_addr(imem_addr), .ihit(ihit), .imem_load(imem_load),
        .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
        .dmem_width(dmem_width), .dmem_store(dmem_store), .dhit(dhit), .dmem_load(dmem_load),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // Structural invariants sampled on the falling edge.
    always @(negedge clk) begin
        if (nrst) begin
            n_checks++;
            if (ihit && dhit) begin n_fail++; $display("FAIL hit_overlap: ihit=%b dhit=%b required not both", ihit, dhit); end
            n_checks++;
            if (mem_ren && mem_wen) begin n_fail++; $display("FAIL strobe_overlap: ren=%b wen=%b required not both", mem_ren, mem_wen); end
        end
    end

    // Reference model: an access covers bytes [off, off+n); store bytes repeat every n lanes.
    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction
    function automatic bit legal(input logic [1:0] sz, input logic [31:0] a);
        return (sz != 2'b11) && ((a % nbytes(sz)) == 0);
    endfunction
    function automatic logic [3:0] ref_strb(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] s;
        int off;
        s = '0;
        off = a % 4;
        for (int k = 0; k < 4; k++) s[k] = (k >= off) && (k < off + nbytes(sz));
        return s;
    endfunction
    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] st);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = st[8*(k % nbytes(sz)) +: 8];
        return w;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        imem_ren = 0; dmem_ren = 0; dmem_wen = 0; mem_ready = 0;
    endtask

    task automatic test_reset;
        logic [136:0] outs;
        nrst = 0; imem_ren = 1; imem_addr = 32'h44; mem_ready = 1;
        #1;
        outs = {mem_ren, mem_wen, ihit, dhit, mem_addr, mem_wdata, mem_wstrb, imem_load, dmem_load};
        n_checks++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_outs: got %h required 0", outs); end
        tick; tick;
        n_checks++;
        if (mem_ren !== 1'b0 || ihit !== 1'b0) begin n_fail++; $display("FAIL reset_hold: ren=%b ihit=%b required 0 0", mem_ren, ihit); end
        idle_inputs;
        #3 nrst = 1;
        tick;
        n_checks++;
        if (mem_ren !== 1'b0 || mem_wen !== 1'b0) begin n_fail++; $display("FAIL reset_idle: ren=%b wen=%b required 0 0", mem_ren, mem_wen); end
    endtask

    task automatic test_fetch;
        logic [31:0] rd;
        imem_ren = 1; imem_addr = 32'h100;
        tick;
        n_checks++;
        if (mem_ren !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL fetch_grant: ren=%b addr=%h required 1 00000100", mem_ren, mem_addr); end
        for (int c = 0; c < 2; c++) begin
            imem_addr = $urandom;
            tick;
            n_checks++;
            if (mem_ren !== 1'b1 || mem_addr !== 32'h100 || ihit !== 1'b0) begin
                n_fail++; $display("FAIL fetch_hold: ren=%b addr=%h ihit=%b required 1 00000100 0", mem_ren, mem_addr, ihit);
            end
        end
        tick;
        rd = $urandom; mem_rdata = rd; mem_ready = 1;
        #1;
        n_checks++;
        if (ihit !== 1'b1 || imem_load !== rd || dhit !== 1'b0) begin
            n_fail++; $display("FAIL fetch_hit: ihit=%b load=%h dhit=%b required 1 %h 0", ihit, imem_load, dhit, rd);
        end
        tick;
        mem_ready = 0; imem_ren = 0;
        #1;
        n_checks++;
        if (ihit !== 1'b0 || mem_ren !== 1'b0) begin n_fail++; $display("FAIL fetch_done: ihit=%b ren=%b required 0 0", ihit, mem_ren); end
    endtask

    task automatic test_store_byte;
        logic [31:0] rd;
        imem_ren = 1; imem_addr = 32'h180;
        dmem_wen = 1; dmem_addr = 32'h203; dmem_width = 3'b100;
        dmem_store = {$urandom_range(0, 32'hFFFFFF), 8'hAB} ;
        tick;
        n_checks++;
        if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_wstrb !== 4'b1000 || mem_wdata !== 32'hABABABAB || mem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL store_byte: wen=%b ren=%b strb=%b wdata=%h addr=%h required 1 0 1000 abababab 00000200",
                     mem_wen, mem_ren, mem_wstrb, mem_wdata, mem_addr);
        end
        mem_ready = 1;
        #1;
        n_checks++;
        if (dhit !== 1'b1 || ihit !== 1'b0) begin n_fail++; $display("FAIL store_hit: dhit=%b ihit=%b required 1 0", dhit, ihit); end
        tick;
        mem_ready = 0; dmem_wen = 0;
        #1;
        tick;
        n_checks++;
        if (mem_ren !== 1'b1 || mem_addr !== 32'h180) begin n_fail++; $display("FAIL store_then_fetch: ren=%b addr=%h required 1 00000180", mem_ren, mem_addr); end
        rd = $urandom; mem_rdata = rd; mem_ready = 1;
        #1;
        n_checks++;
        if (ihit !== 1'b1 || imem_load !== rd) begin n_fail++; $display("FAIL store_fetch_hit: ihit=%b load=%h required 1 %h", ihit, imem_load, rd); end
        tick;
        idle_inputs;
    endtask

    task automatic test_load_half;
        dmem_ren = 1; dmem_addr = 32'h42; dmem_width = 3'b001;
        tick;
        n_checks++;
        if (mem_ren !== 1'b1 || mem_wstrb !== 4'b0000 || mem_addr !== 32'h40) begin
            n_fail++; $display("FAIL half_grant: ren=%b strb=%b addr=%h required 1 0000 00000040", mem_ren, mem_wstrb, mem_addr);
        end
        mem_rdata = 32'hBEEF1234; mem_ready = 1;
        #1;
        n_checks++;
        if (dhit !== 1'b1 || dmem_load !== 32'h0000BEEF) begin
            n_fail++; $display("FAIL half_load: dhit=%b load=%h required 1 0000beef", dhit, dmem_load);
        end
        tick;
        idle_inputs;
    endtask

    task automatic test_illegal;
        logic [31:0] bad_addr [3];
        logic [2:0]  bad_w    [3];
        bad_addr[0] = 32'h41; bad_w[0] = 3'b010;
        bad_addr[1] = 32'h43; bad_w[1] = 3'b001;
        bad_addr[2] = 32'h40; bad_w[2] = 3'b011;
        dmem_ren = 1; dmem_addr = bad_addr[0]; dmem_width = bad_w[0];
        imem_ren = 1; imem_addr = 32'h300;
        tick;
        n_checks++;
        if (mem_ren !== 1'b1 || mem_addr !== 32'h300) begin n_fail++; $display("FAIL illegal_fetch: ren=%b addr=%h required 1 00000300", mem_ren, mem_addr); end
        mem_ready = 1;
        #1;
        n_checks++;
        if (ihit !== 1'b1 || dhit !== 1'b0) begin n_fail++; $display("FAIL illegal_fetch_hit: ihit=%b dhit=%b required 1 0", ihit, dhit); end
        tick;
        imem_ren = 0;
        for (int b = 0; b < 3; b++) begin
            dmem_ren = b[0]; dmem_wen = ~b[0]; dmem_addr = bad_addr[b]; dmem_width = bad_w[b];
            for (int c = 0; c < 3; c++) begin
                tick;
                n_checks++;
                if (mem_ren !== 1'b0 || mem_wen !== 1'b0 || dhit !== 1'b0) begin
                    n_fail++; $display("FAIL illegal_issue[%0d]: ren=%b wen=%b dhit=%b required 0 0 0", b, mem_ren, mem_wen, dhit);
                end
            end
        end
        tick;
        idle_inputs;
    endtask

    task automatic test_random;
        for (int it = 0; it < 60; it++) begin
            bit          is_data, do_abort, ok, wr;
            int          lat;
            logic [31:0] a, st, rd, exp_addr, exp_load;
            logic [2:0]  w;
            int          rw;
            is_data  = $urandom_range(0, 2) != 0;
            do_abort = $urandom_range(0, 4) == 0;
            lat      = $urandom_range(1, 4);
            a = $urandom; st = $urandom; w = 3'($urandom_range(0, 7)); rw = $urandom_range(0, 2);
            if (is_data) begin
                ok = legal(w[1:0], a);
                wr = (rw == 1);
                dmem_ren = (rw != 1); dmem_wen = (rw != 0);
                dmem_addr = a; dmem_width = w; dmem_store = st;
            end else begin
                ok = 1; wr = 0;
                a = {a[31:2], 2'b00};
                imem_ren = 1; imem_addr = a;
            end
            exp_addr = {a[31:2], 2'b00};
            tick;
            if (!ok) begin
                mem_ready = 1;
                #1;
                n_checks++;
                if (mem_ren !== 1'b0 || mem_wen !== 1'b0 || dhit !== 1'b0) begin
                    n_fail++; $display("FAIL rand_illegal[%0d]: ren=%b wen=%b dhit=%b required 0 0 0", it, mem_ren, mem_wen, dhit);
                end
            end else begin
                n_checks++;
                if (mem_ren !== !wr || mem_wen !== wr || mem_addr !== exp_addr
                    || mem_wstrb !== (wr ? ref_strb(w[1:0], a) : 4'h0)
                    || (wr && mem_wdata !== ref_wdata(w[1:0], st))) begin
                    n_fail++;
                    $display("FAIL rand_grant[%0d]: ren=%b wen=%b addr=%h strb=%b wdata=%h required %b %b %h %b %h",
                             it, mem_ren, mem_wen, mem_addr, mem_wstrb, mem_wdata, !wr, wr, exp_addr,
                             wr ? ref_strb(w[1:0], a) : 4'h0, ref_wdata(w[1:0], st));
                end
                if (do_abort) begin
                    imem_ren = 0; dmem_ren = 0; dmem_wen = 0;
                end else if (is_data) begin
                    dmem_addr = $urandom; dmem_store = $urandom; dmem_width = 3'($urandom_range(0, 7));
                end else begin
                    imem_addr = $urandom;
                end
                for (int c = 1; c <= lat; c++) begin
                    if (c > 1) tick;
                    if (c == lat) begin
                        rd = $urandom; mem_rdata = rd; mem_ready = 1;
                        exp_load = rd >> (8 * (a % 4));
                        #1;
                        n_checks++;
                        if (is_data && (dhit !== !do_abort || dmem_load !== (do_abort ? 32'h0 : exp_load) || ihit !== 1'b0)) begin
                            n_fail++; $display("FAIL rand_dhit[%0d]: dhit=%b load=%h ihit=%b required %b %h 0",
                                               it, dhit, dmem_load, ihit, !do_abort, do_abort ? 32'h0 : exp_load);
                        end else if (!is_data && (ihit !== !do_abort || imem_load !== (do_abort ? 32'h0 : rd) || dhit !== 1'b0)) begin
                            n_fail++; $display("FAIL rand_ihit[%0d]: ihit=%b load=%h dhit=%b required %b %h 0",
                                               it, ihit, imem_load, dhit, !do_abort, do_abort ? 32'h0 : rd);
                        end
                    end else begin
                        n_checks++;
                        if (mem_addr !== exp_addr || mem_ren !== !wr || mem_wen !== wr || ihit !== 1'b0 || dhit !== 1'b0) begin
                            n_fail++; $display("FAIL rand_hold[%0d]: addr=%h ren=%b wen=%b required %h %b %b",
                                               it, mem_addr, mem_ren, mem_wen, exp_addr, !wr, wr);
                        end
                    end
                end
            end
            tick;
            idle_inputs;
            #1;
            n_checks++;
            if (mem_ren !== 1'b0 || mem_wen !== 1'b0) begin n_fail++; $display("FAIL rand_idle[%0d]: ren=%b wen=%b required 0 0", it, mem_ren, mem_wen); end
        end
    endtask

    task automatic test_back_to_back;
        int  run;
        byte exp_who, got_who;
        run = 0;
        imem_ren = 1; imem_addr = 32'h500;
        dmem_ren = 1; dmem_addr = 32'h400; dmem_width = 3'b010;
        for (int g = 0; g < 6; g++) begin
            if (run == SL) begin exp_who = "I"; run = 0; end
            else begin exp_who = "D"; run++; end
            tick;
            got_who = !mem_ren ? "-" : (mem_addr == 32'h500) ? "I" : (mem_addr == 32'h400) ? "D" : "?";
            mem_ready = 1;
            #1;
            n_checks++;
            if (got_who !== exp_who || ihit !== (exp_who == "I") || dhit !== (exp_who == "D")) begin
                n_fail++; $display("FAIL starve_grant[%0d]: got %c ihit=%b dhit=%b required %c", g, got_who, ihit, dhit, exp_who);
            end
            tick;
            mem_ready = 0;
        end
        idle_inputs;
        tick;
    endtask

    task automatic test_reset_busy;
        logic [136:0] outs;
        dmem_wen = 1; dmem_addr = 32'h10; dmem_width = 3'b010; dmem_store = $urandom;
        tick;
        n_checks++;
        if (mem_wen !== 1'b1 || mem_wstrb !== 4'b1111) begin n_fail++; $display("FAIL rstbusy_grant: wen=%b strb=%b required 1 1111", mem_wen, mem_wstrb); end
        #2 nrst = 0; mem_ready = 1;
        #1;
        outs = {mem_ren, mem_wen, ihit, dhit, mem_addr, mem_wdata, mem_wstrb, imem_load, dmem_load};
        n_checks++;
        if (outs !== '0) begin n_fail++; $display("FAIL rstbusy_outs: got %h required 0", outs); end
        dmem_wen = 0;
        #2 nrst = 1;
        for (int c = 0; c < 2; c++) begin
            tick;
            n_checks++;
            if (dhit !== 1'b0 || mem_ren !== 1'b0 || mem_wen !== 1'b0) begin
                n_fail++; $display("FAIL rstbusy_after: dhit=%b ren=%b wen=%b required 0 0 0", dhit, mem_ren, mem_wen);
            end
        end
        idle_inputs;
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_store_byte;
        test_load_half;
        test_illegal;
        test_random;
        test_back_to_back;
        test_reset_busy;
        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
